// File: rtl/rst_spec.sv
// Register status table with multi-level branch speculation: per-register busy/tag
// and a mask of unresolved branches, with out-of-order resolve and nested squash.
module rst_spec #(
  parameter int NREG     = 32,
  parameter int TAG_W    = 2,
  parameter int BR_DEPTH = 4,
  parameter int WB_PORTS = 2,
  parameter int ZERO_REG = 1,
  localparam int SEL_W   = $clog2(NREG),
  localparam int BID_W   = (BR_DEPTH > 1) ? $clog2(BR_DEPTH) : 1
) (
  input  logic                      CLK,
  input  logic                      nRST,
  input  logic                      di_write,
  input  logic [SEL_W-1:0]          di_sel,
  input  logic [TAG_W-1:0]          di_tag,
  input  logic                      di_br_alloc,
  output logic [BID_W-1:0]          br_alloc_id,
  output logic                      br_full,
  output logic                      spec_active,
  input  logic                      br_resolve,
  input  logic [BID_W-1:0]          br_resolve_id,
  input  logic                      br_miss,
  input  logic [BID_W-1:0]          br_miss_id,
  input  logic [WB_PORTS-1:0]       wb_write,
  input  logic [WB_PORTS*SEL_W-1:0] wb_sel,
  input  logic [SEL_W-1:0]          rs1_sel,
  input  logic [SEL_W-1:0]          rs2_sel,
  input  logic [SEL_W-1:0]          rd_sel,
  output logic [TAG_W-1:0]          rs1_tag,
  output logic [TAG_W-1:0]          rs2_tag,
  output logic                      rd_busy
);

  logic [NREG-1:0]                     busy_q, busy_d;
  logic [NREG-1:0][TAG_W-1:0]          tag_q, tag_d;
  logic [NREG-1:0][BR_DEPTH-1:0]       smask_q, smask_d;
  logic [BR_DEPTH-1:0]                 bvalid_q, bvalid_d;
  logic [BR_DEPTH-1:0][BR_DEPTH-1:0]   bdep_q, bdep_d;

  logic                miss_ok, res_ok, disp_ok, alloc_ok;
  logic [BR_DEPTH-1:0] res_mask, kill_mask, live;
  logic [NREG-1:0]     wb_clr;

  // Branch bookkeeping and per-cycle control decisions, all from registered state.
  always_comb begin
    br_alloc_id = '0;
    for (int i = BR_DEPTH-1; i >= 0; i--) begin
      if (!bvalid_q[i]) br_alloc_id = BID_W'(i);
    end
    br_full     = &bvalid_q;
    spec_active = |bvalid_q;

    miss_ok = br_miss && bvalid_q[br_miss_id];
    res_ok  = br_resolve && bvalid_q[br_resolve_id] &&
              !(miss_ok && (br_miss_id == br_resolve_id));

    res_mask = '0;
    if (res_ok) res_mask[br_resolve_id] = 1'b1;

    kill_mask = '0;
    if (miss_ok) begin
      kill_mask[br_miss_id] = 1'b1;
      for (int j = 0; j < BR_DEPTH; j++) begin
        if (bvalid_q[j] && bdep_q[j][br_miss_id]) kill_mask[j] = 1'b1;
      end
    end

    live = bvalid_q & ~res_mask;
    // The dispatching instruction is younger than any valid mispredicted branch.
    disp_ok  = di_write && !miss_ok && !((ZERO_REG != 0) && (di_sel == '0));
    alloc_ok = di_br_alloc && !br_full && !miss_ok;

    wb_clr = '0;
    for (int p = 0; p < WB_PORTS; p++) begin
      if (wb_write[p]) wb_clr[wb_sel[p*SEL_W +: SEL_W]] = 1'b1;
    end
  end

  always_comb begin
    bvalid_d = bvalid_q & ~res_mask & ~kill_mask;
    for (int j = 0; j < BR_DEPTH; j++) bdep_d[j] = bdep_q[j] & ~res_mask;
    if (alloc_ok) begin
      bvalid_d[br_alloc_id] = 1'b1;
      bdep_d[br_alloc_id]   = live;
    end

    // Per register: squash > dispatch write > writeback > resolve mask update.
    for (int r = 0; r < NREG; r++) begin
      busy_d[r]  = busy_q[r];
      tag_d[r]   = tag_q[r];
      smask_d[r] = smask_q[r] & ~res_mask;
      if (|(smask_q[r] & kill_mask)) begin
        busy_d[r]  = 1'b0;
        tag_d[r]   = '0;
        smask_d[r] = '0;
      end else if (disp_ok && (di_sel == SEL_W'(r))) begin
        busy_d[r]  = 1'b1;
        tag_d[r]   = di_tag;
        smask_d[r] = live;
      end else if (wb_clr[r]) begin
        busy_d[r]  = 1'b0;
        tag_d[r]   = '0;
        smask_d[r] = '0;
      end
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      busy_q   <= '0;
      tag_q    <= '0;
      smask_q  <= '0;
      bvalid_q <= '0;
      bdep_q   <= '0;
    end else begin
      busy_q   <= busy_d;
      tag_q    <= tag_d;
      smask_q  <= smask_d;
      bvalid_q <= bvalid_d;
      bdep_q   <= bdep_d;
    end
  end

  assign rs1_tag = busy_q[rs1_sel] ? tag_q[rs1_sel] : '0;
  assign rs2_tag = busy_q[rs2_sel] ? tag_q[rs2_sel] : '0;
  assign rd_busy = busy_q[rd_sel];

endmodule

// File: tb/tb_rst_spec.sv
// Bench for rst_spec: directed vector table, asynchronous reset sequence, and
// randomized traffic checked against an age-ordered branch reference model.
module tb_rst_spec;

  logic       CLK, nRST;
  logic       di_write, di_br_alloc;
  logic [4:0] di_sel;
  logic [1:0] di_tag;
  logic [1:0] br_alloc_id;
  logic       br_full, spec_active;
  logic       br_resolve, br_miss;
  logic [1:0] br_resolve_id, br_miss_id;
  logic [1:0] wb_write;
  logic [9:0] wb_sel;
  logic [4:0] rs1_sel, rs2_sel, rd_sel;
  logic [1:0] rs1_tag, rs2_tag;
  logic       rd_busy;

  int checks = 0;
  int errors = 0;

  rst_spec dut (
    .CLK(CLK), .nRST(nRST),
    .di_write(di_write), .di_sel(di_sel), .di_tag(di_tag),
    .di_br_alloc(di_br_alloc), .br_alloc_id(br_alloc_id),
    .br_full(br_full), .spec_active(spec_active),
    .br_resolve(br_resolve), .br_resolve_id(br_resolve_id),
    .br_miss(br_miss), .br_miss_id(br_miss_id),
    .wb_write(wb_write), .wb_sel(wb_sel),
    .rs1_sel(rs1_sel), .rs2_sel(rs2_sel), .rd_sel(rd_sel),
    .rs1_tag(rs1_tag), .rs2_tag(rs2_tag), .rd_busy(rd_busy)
  );

  // Clock and reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic wr; logic [4:0] sel; logic [1:0] tag; logic al;
    logic rs; logic [1:0] rid; logic ms; logic [1:0] mid;
    logic [1:0] wbw; logic [4:0] wb0; logic [4:0] wb1;
    logic [4:0] l1; logic [4:0] l2; logic [4:0] ld;
    logic [1:0] e1; logic [1:0] e2; logic ed;
    logic [1:0] eaid; logic chk_aid; logic efull; logic espec;
  } vec_t;

  vec_t vt[24];

  // Reference model: registers remember which live branches they depend on;
  // branches are kept in allocation order so a miss kills itself and everything younger.
  bit         m_busy[32];
  logic [1:0] m_tag[32];
  logic [3:0] m_dep[32];
  int         age_q[$];
  logic [8:0] exp_q[$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic wr, input logic [4:0] sel, input logic [1:0] tag,
                       input logic al, input logic rs, input logic [1:0] rid,
                       input logic ms, input logic [1:0] mid, input logic [1:0] wbw,
                       input logic [4:0] wb0, input logic [4:0] wb1,
                       input logic [4:0] l1, input logic [4:0] l2, input logic [4:0] ld);
    di_write = wr; di_sel = sel; di_tag = tag; di_br_alloc = al;
    br_resolve = rs; br_resolve_id = rid; br_miss = ms; br_miss_id = mid;
    wb_write = wbw; wb_sel = {wb1, wb0};
    rs1_sel = l1; rs2_sel = l2; rd_sel = ld;
  endtask

  task automatic drive_idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  function automatic logic [3:0] live_mask();
    logic [3:0] m = '0;
    foreach (age_q[i]) m[age_q[i]] = 1'b1;
    return m;
  endfunction

  task automatic model_reset();
    for (int r = 0; r < 32; r++) begin
      m_busy[r] = 0; m_tag[r] = '0; m_dep[r] = '0;
    end
    age_q.delete();
  endtask

  task automatic model_step(input logic wr, input logic [4:0] sel, input logic [1:0] tag,
                            input logic al, input logic rs, input logic [1:0] rid,
                            input logic ms, input logic [1:0] mid, input logic [1:0] wbw,
                            input logic [4:0] wb0, input logic [4:0] wb1);
    logic [3:0] live = live_mask();
    logic [3:0] kill = '0;
    logic [3:0] res  = '0;
    bit miss_ok = ms && live[mid];
    bit res_ok  = rs && live[rid] && !(miss_ok && mid == rid);
    int alloc = -1;
    int newq[$];
    if (res_ok) res[rid] = 1'b1;
    if (miss_ok) begin
      int pos = 0;
      foreach (age_q[i]) if (age_q[i] == int'(mid)) pos = i;
      for (int i = pos; i < age_q.size(); i++) kill[age_q[i]] = 1'b1;
    end
    if (al && age_q.size() < 4 && !miss_ok) begin
      for (int b = 3; b >= 0; b--) if (!live[b]) alloc = b;
    end
    for (int r = 0; r < 32; r++) begin
      bit wb_hit = (wbw[0] && wb0 == r) || (wbw[1] && wb1 == r);
      if (miss_ok && (m_dep[r] & kill) != 0) begin
        m_busy[r] = 0; m_tag[r] = 0; m_dep[r] = 0;
      end else if (wr && !miss_ok && sel == r && r != 0) begin
        m_busy[r] = 1; m_tag[r] = tag; m_dep[r] = live & ~res;
      end else if (wb_hit) begin
        m_busy[r] = 0; m_tag[r] = 0; m_dep[r] = 0;
      end else begin
        m_dep[r] = m_dep[r] & ~res;
      end
    end
    foreach (age_q[i]) if (!res[age_q[i]] && !kill[age_q[i]]) newq.push_back(age_q[i]);
    if (alloc >= 0) newq.push_back(alloc);
    age_q = newq;
  endtask

  function automatic logic [8:0] model_expect(input logic [4:0] l1, input logic [4:0] l2,
                                              input logic [4:0] ld);
    logic [3:0] live = live_mask();
    logic [1:0] aid = 2'd0;
    logic [1:0] t1 = m_busy[l1] ? m_tag[l1] : 2'd0;
    logic [1:0] t2 = m_busy[l2] ? m_tag[l2] : 2'd0;
    for (int b = 3; b >= 0; b--) if (!live[b]) aid = 2'(b);
    return {t1, t2, m_busy[ld], aid, (age_q.size() == 4), (age_q.size() != 0)};
  endfunction

  initial begin
    // Directed vectors: inputs applied for one edge, outputs checked just after it.
    vt[0]  = '{1,5,2,0, 0,0,0,0, 0,0,0, 5,0,5,   2,0,1,0,1,0,0};
    vt[1]  = '{0,0,0,0, 0,0,0,0, 2,0,5, 5,5,5,   0,0,0,0,1,0,0};
    vt[2]  = '{0,0,0,1, 0,0,0,0, 0,0,0, 0,0,0,   0,0,0,1,1,0,1};
    vt[3]  = '{1,3,1,1, 0,0,0,0, 0,0,0, 3,0,3,   1,0,1,2,1,0,1};
    vt[4]  = '{1,4,2,1, 0,0,0,0, 0,0,0, 4,3,4,   2,1,1,3,1,0,1};
    vt[5]  = '{1,6,3,0, 0,0,0,0, 0,0,0, 6,4,6,   3,2,1,3,1,0,1};
    vt[6]  = '{0,0,0,0, 0,0,1,1, 0,0,0, 4,6,3,   0,0,1,1,1,0,1};
    vt[7]  = '{0,0,0,0, 0,0,0,0, 0,0,0, 3,4,6,   1,0,0,1,1,0,1};
    vt[8]  = '{0,0,0,1, 0,0,0,0, 0,0,0, 0,0,0,   0,0,0,2,1,0,1};
    vt[9]  = '{1,7,1,0, 0,0,0,0, 0,0,0, 7,3,7,   1,1,1,2,1,0,1};
    vt[10] = '{0,0,0,0, 1,1,0,0, 0,0,0, 7,3,7,   1,1,1,1,1,0,1};
    vt[11] = '{0,0,0,0, 0,0,1,0, 0,0,0, 7,3,7,   0,0,0,0,1,0,0};
    vt[12] = '{0,0,0,1, 0,0,0,0, 0,0,0, 0,0,0,   0,0,0,1,1,0,1};
    vt[13] = '{0,0,0,1, 0,0,0,0, 0,0,0, 0,0,0,   0,0,0,2,1,0,1};
    vt[14] = '{0,0,0,1, 0,0,0,0, 0,0,0, 0,0,0,   0,0,0,3,1,0,1};
    vt[15] = '{0,0,0,1, 0,0,0,0, 0,0,0, 0,0,0,   0,0,0,0,0,1,1};
    vt[16] = '{0,0,0,1, 0,0,0,0, 0,0,0, 0,0,0,   0,0,0,0,0,1,1};
    vt[17] = '{0,0,0,0, 1,2,0,0, 0,0,0, 0,0,0,   0,0,0,2,1,0,1};
    vt[18] = '{1,9,3,0, 0,0,0,0, 1,9,0, 9,0,9,   3,0,1,2,1,0,1};
    vt[19] = '{1,10,2,0, 0,0,1,0, 0,0,0, 10,9,10, 0,0,0,0,1,0,0};
    vt[20] = '{1,0,1,0, 0,0,0,0, 0,0,0, 0,0,0,   0,0,0,0,1,0,0};
    vt[21] = '{0,0,0,1, 0,0,0,0, 0,0,0, 0,0,0,   0,0,0,1,1,0,1};
    vt[22] = '{1,11,1,0, 0,0,0,0, 0,0,0, 11,0,11, 1,0,1,1,1,0,1};
    vt[23] = '{0,0,0,0, 1,0,1,0, 0,0,0, 11,0,11, 0,0,0,0,1,0,0};

    drive_idle();
    nRST = 1'b0;
    #12;
    chk("reset rs1_tag", rs1_tag, 0);
    chk("reset rd_busy", rd_busy, 0);
    chk("reset spec_active", spec_active, 0);
    chk("reset br_full", br_full, 0);
    chk("reset br_alloc_id", br_alloc_id, 0);
    @(negedge CLK);
    nRST = 1'b1;

    for (int i = 0; i < 24; i++) begin
      @(negedge CLK);
      drive(vt[i].wr, vt[i].sel, vt[i].tag, vt[i].al, vt[i].rs, vt[i].rid,
            vt[i].ms, vt[i].mid, vt[i].wbw, vt[i].wb0, vt[i].wb1,
            vt[i].l1, vt[i].l2, vt[i].ld);
      @(posedge CLK);
      #1;
      chk($sformatf("row%0d rs1_tag", i), rs1_tag, vt[i].e1);
      chk($sformatf("row%0d rs2_tag", i), rs2_tag, vt[i].e2);
      chk($sformatf("row%0d rd_busy", i), rd_busy, vt[i].ed);
      if (vt[i].chk_aid) chk($sformatf("row%0d br_alloc_id", i), br_alloc_id, vt[i].eaid);
      chk($sformatf("row%0d br_full", i), br_full, vt[i].efull);
      chk($sformatf("row%0d spec_active", i), spec_active, vt[i].espec);
    end

    // Mid-flight reset: three branches live, five registers busy.
    for (int i = 1; i <= 5; i++) begin
      @(negedge CLK);
      drive(1, 5'(i), 2'(i % 3 + 1), (i <= 3), 0, 0, 0, 0, 0, 0, 0, 1, 3, 5);
    end
    @(negedge CLK);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 3, 5);
    #1;
    chk("preflight rs1_tag", rs1_tag, 2);
    chk("preflight rs2_tag", rs2_tag, 1);
    chk("preflight rd_busy", rd_busy, 1);
    chk("preflight br_alloc_id", br_alloc_id, 3);
    #2 nRST = 1'b0;
    #1;
    chk("async rs1_tag", rs1_tag, 0);
    chk("async rs2_tag", rs2_tag, 0);
    chk("async rd_busy", rd_busy, 0);
    chk("async spec_active", spec_active, 0);
    chk("async br_full", br_full, 0);
    chk("async br_alloc_id", br_alloc_id, 0);
    @(negedge CLK);
    nRST = 1'b1;
    rs1_sel = 5'd2; rs2_sel = 5'd4;
    @(posedge CLK);
    #1;
    chk("post reset rs1_tag", rs1_tag, 0);
    chk("post reset rs2_tag", rs2_tag, 0);
    chk("post reset rd_busy", rd_busy, 0);
    chk("post reset spec_active", spec_active, 0);

    // Randomized traffic against the reference model.
    model_reset();
    for (int i = 0; i < 3000; i++) begin
      logic wr, al, rs, ms;
      logic [4:0] sel, wb0, wb1, l1, l2, ld;
      logic [1:0] tag, rid, mid, wbw;
      logic [8:0] v;
      @(negedge CLK);
      if (i % 700 == 699) begin
        drive_idle();
        nRST = 1'b0;
        #2 nRST = 1'b1;
        model_reset();
      end
      wr  = 1'($urandom_range(0, 1));
      sel = 5'($urandom_range(0, 11));
      tag = 2'($urandom_range(0, 3));
      al  = ($urandom_range(0, 9) < 4);
      rs  = ($urandom_range(0, 9) < 3);
      rid = 2'($urandom_range(0, 3));
      ms  = ($urandom_range(0, 19) < 2);
      mid = 2'($urandom_range(0, 3));
      wbw = 2'($urandom_range(0, 3));
      wb0 = 5'($urandom_range(0, 11));
      wb1 = 5'($urandom_range(0, 11));
      l1  = 5'($urandom_range(0, 11));
      l2  = 5'($urandom_range(0, 11));
      ld  = 5'($urandom_range(0, 11));
      drive(wr, sel, tag, al, rs, rid, ms, mid, wbw, wb0, wb1, l1, l2, ld);
      model_step(wr, sel, tag, al, rs, rid, ms, mid, wbw, wb0, wb1);
      exp_q.push_back(model_expect(l1, l2, ld));
      @(posedge CLK);
      #1;
      v = exp_q.pop_front();
      chk($sformatf("rand%0d rs1_tag", i), rs1_tag, v[8:7]);
      chk($sformatf("rand%0d rs2_tag", i), rs2_tag, v[6:5]);
      chk($sformatf("rand%0d rd_busy", i), rd_busy, v[4]);
      if (!v[1]) chk($sformatf("rand%0d br_alloc_id", i), br_alloc_id, v[3:2]);
      chk($sformatf("rand%0d br_full", i), br_full, v[1]);
      chk($sformatf("rand%0d spec_active", i), spec_active, v[0]);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
